// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
//   Moore control FSM for a shared-memory multi-cycle MIPS datapath. Sequences
//   fetch, decode, execute, memory and writeback; supports R-type, lw, sw,
//   addi, beq, bne, j and jal. Also provides a memory-ready handshake, an
//   illegal-opcode pulse and a retired-instruction counter.
//
// Ports
//   clk, rst_n        : rising-edge clock, synchronous active-low reset
//   Opcode            : IR[31:26], stable from DECODE to end of instruction
//   mem_ready         : memory completes the access this cycle
//   IorD .. PCSrc     : datapath mux selects and write strobes
//   illegal_op        : one-cycle pulse in DECODE on an unrecognised opcode
//   instr_done        : one-cycle pulse in the final state of an instruction
//   instr_count       : retired-instruction count (wraps)
//   state             : current state code, debug only
module mips_multicycle_control #(
    parameter int              OP_W     = 6,
    parameter int              ALUOP_W  = 2,
    parameter int              CNT_W    = 32,
    parameter bit              MEM_HS   = 1'b1,
    parameter logic [OP_W-1:0] OP_RTYPE = 6'b000000,
    parameter logic [OP_W-1:0] OP_LW    = 6'b100011,
    parameter logic [OP_W-1:0] OP_SW    = 6'b101011,
    parameter logic [OP_W-1:0] OP_ADDI  = 6'b001000,
    parameter logic [OP_W-1:0] OP_BEQ   = 6'b000100,
    parameter logic [OP_W-1:0] OP_BNE   = 6'b000101,
    parameter logic [OP_W-1:0] OP_J     = 6'b000010,
    parameter logic [OP_W-1:0] OP_JAL   = 6'b000011
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    Opcode,
    input  logic               mem_ready,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               Branch,
    output logic               BranchNe,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSrc,
    output logic               illegal_op,
    output logic               instr_done,
    output logic [CNT_W-1:0]   instr_count,
    output logic [3:0]         state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_ADDIEX = 4'd8,  S_ADDIWB = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
        S_JAL    = 4'd12
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             w_ready;
    logic [1:0]       w_aluop;
    logic             w_done;

    // With the handshake disabled every wait state exits after one cycle.
    assign w_ready = MEM_HS ? mem_ready : 1'b1;

    // State register and retired-instruction counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_done) r_count <= r_count + CNT_W'(1);
        end
    end

    // Next-state logic.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (Opcode == OP_LW || Opcode == OP_SW)       w_next = S_MEMADR;
                else if (Opcode == OP_RTYPE)                  w_next = S_EXEC;
                else if (Opcode == OP_ADDI)                   w_next = S_ADDIEX;
                else if (Opcode == OP_BEQ || Opcode == OP_BNE) w_next = S_BRANCH;
                else if (Opcode == OP_J)                      w_next = S_JUMP;
                else if (Opcode == OP_JAL)                    w_next = S_JAL;
                else                                          w_next = S_FETCH;
            end
            S_MEMADR: begin
                if (Opcode == OP_SW)      w_next = S_MEMWR;
                else if (Opcode == OP_LW) w_next = S_MEMRD;
                else                      w_next = S_FETCH;
            end
            S_MEMRD:  w_next = w_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = w_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;  // writeback/branch/jump states and unused codes
        endcase
    end

    // Output decode (Moore, except the FETCH IR/PC strobes follow mem_ready).
    always_comb begin
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        BranchNe   = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 2'b00;
        MemtoReg   = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        w_aluop    = 2'b00;
        PCSrc      = 2'b00;
        illegal_op = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = w_ready;
                PCWrite = w_ready;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = !(Opcode == OP_LW   || Opcode == OP_SW  ||
                               Opcode == OP_RTYPE || Opcode == OP_ADDI ||
                               Opcode == OP_BEQ  || Opcode == OP_BNE ||
                               Opcode == OP_J    || Opcode == OP_JAL);
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 2'b01;
                RegWrite = 1'b1;
                w_done   = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                w_done   = w_ready;  // retires only on the completing cycle
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                w_aluop = 2'b10;
            end
            S_ALUWB: begin
                RegDst   = 2'b01;
                RegWrite = 1'b1;
                w_done   = 1'b1;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                w_done   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                w_aluop  = 2'b01;
                PCSrc    = 2'b01;
                Branch   = (Opcode == OP_BEQ);
                BranchNe = (Opcode == OP_BNE);
                w_done   = 1'b1;
            end
            S_JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
                w_done  = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value.
                PCSrc    = 2'b10;
                PCWrite  = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                RegWrite = 1'b1;
                w_done   = 1'b1;
            end
            default: ;
        endcase
        // No architectural state may change while reset is held.
        if (!rst_n) begin
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            Branch   = 1'b0;
            BranchNe = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign ALUOp       = ALUOP_W'(w_aluop);
    assign instr_done  = w_done;
    assign instr_count = r_count;
    assign state       = r_state;

endmodule
